// File: rtl/debug_uart_tx_if.sv
// Handshake bundle between the debug FIFO drain stage and its neighbours:
// FIFO head/empty view and pop strobe, plus the UART line and status flags.
interface debug_uart_tx_if #(
    parameter int DBIT = 8
);
    logic            en;
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_rdata;
    logic            fifo_rd;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output en, fifo_empty, fifo_rdata,
        input  fifo_rd, tx, tx_busy, tx_done_tick
    );

    modport slave (
        input  en, fifo_empty, fifo_rdata,
        output fifo_rd, tx, tx_busy, tx_done_tick
    );
endinterface

// File: rtl/debug_uart_tx.sv
// debug_uart_tx: pops the debug FIFO one byte at a time and sends it LSB first on a UART line.
// Define DEBUG_UART_PARITY_EN to add an even parity bit after the data bits.
module debug_uart_tx #(
    parameter int DBIT    = 8,
    parameter int CLK_DIV = 5208
) (
    input  logic           clk,
    input  logic           reset,
    debug_uart_tx_if.slave bus
);
    localparam int            IW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [15:0]   CNT_MAX = 16'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DBIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef DEBUG_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_nxt;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nxt;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] w_shift_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            r_fifo_rd;
    logic            w_tick;
    logic            w_fetch;
`ifdef DEBUG_UART_PARITY_EN
    logic            r_par;
`endif

    assign w_tick  = (r_cnt == CNT_MAX);
    // The pop is only ever requested from IDLE, so the empty flag is ignored mid-frame.
    assign w_fetch = (r_state == S_IDLE) && bus.en && !bus.fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fetch) w_state_nxt = S_START;
            S_START: if (w_tick) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_tick && (r_idx == IDX_MAX)) begin
`ifdef DEBUG_UART_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef DEBUG_UART_PARITY_EN
            S_PARITY: if (w_tick) w_state_nxt = S_STOP;
`endif
            S_STOP:  if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // tx is registered, so its next value is derived from the next state and next shift value.
    always_comb begin
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        if (w_fetch) begin
            w_shift_nxt = bus.fifo_rdata;
        end else if ((r_state == S_DATA) && w_tick) begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end

        if ((r_state == S_IDLE) || w_tick || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 16'd1;
        end

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef DEBUG_UART_PARITY_EN
            S_PARITY: w_tx_nxt = r_par;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_fifo_rd <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_fifo_rd <= w_fetch;
        end
    end

`ifdef DEBUG_UART_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par <= 1'b0;
        end else if (w_fetch) begin
            r_par <= ^bus.fifo_rdata;
        end
    end
`endif

    assign bus.fifo_rd      = r_fifo_rd;
    assign bus.tx           = r_tx;
    assign bus.tx_busy      = (r_state != S_IDLE);
    assign bus.tx_done_tick = (r_state == S_STOP) && w_tick;
endmodule

// File: tb/tb_debug_uart_tx.sv
// Directed bench for debug_uart_tx with CLK_DIV=4 and a small FIFO model feeding it.
// Define DEBUG_UART_PARITY_EN for the parity build as well.
module tb_debug_uart_tx;
    localparam int CD = 4;
`ifdef DEBUG_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CD;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;

    logic [7:0] mem [16];
    int         head = 0;
    int         count = 0;

    debug_uart_tx_if #(.DBIT(8)) bus ();

    debug_uart_tx #(.DBIT(8), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // FIFO model: head advances at the end of each cycle in which the pop strobe is high.
    always @(posedge clk) begin
        if (bus.fifo_rd) head <= head + 1;
    end
    assign bus.fifo_empty = (head >= count);
    assign bus.fifo_rdata = mem[head[3:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef DEBUG_UART_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Expects the fetch on the next edge, then checks every cycle of the frame up to 'upto'.
    task automatic run_frame(input logic [7:0] b, input int drop_at, input int upto);
        for (int c = 1; c <= upto; c++) begin
            tick();
            chk($sformatf("tx byte %02h cyc %0d", b, c), bus.tx, exp_bit(b, (c - 1) / CD));
            chk($sformatf("fifo_rd byte %02h cyc %0d", b, c), bus.fifo_rd, c == 1);
            chk($sformatf("tx_busy byte %02h cyc %0d", b, c), bus.tx_busy, 1'b1);
            chk($sformatf("done byte %02h cyc %0d", b, c), bus.tx_done_tick, c == FL);
            if (c == drop_at) bus.en = 1'b0;
        end
    endtask

    task automatic idle_cycle(input string tag);
        tick();
        chk({tag, " tx"}, bus.tx, 1'b1);
        chk({tag, " fifo_rd"}, bus.fifo_rd, 1'b0);
        chk({tag, " tx_busy"}, bus.tx_busy, 1'b0);
        chk({tag, " done"}, bus.tx_done_tick, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[0] = 8'hA5;
        count  = 1;
        bus.en = 1'b1;
        reset  = 1'b0;

        // Reset held with data present and enable high: nothing may start.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rst tx %0d", i), bus.tx, 1'b1);
            chk($sformatf("rst fifo_rd %0d", i), bus.fifo_rd, 1'b0);
            chk($sformatf("rst tx_busy %0d", i), bus.tx_busy, 1'b0);
        end
        chkn("rst no pop", head, 0);
        bus.en = 1'b0;
        reset  = 1'b1;
        idle_cycle("post-rst idle0");
        idle_cycle("post-rst idle1");

        // Single byte 0xA5.
        bus.en = 1'b1;
        run_frame(8'hA5, 0, FL);
        for (int i = 0; i < 3; i++) idle_cycle($sformatf("empty idle %0d", i));
        chkn("single pops", head, 1);

        // Back-to-back 0x00, 0xFF, 0x3C.
        mem[1] = 8'h00;
        mem[2] = 8'hFF;
        mem[3] = 8'h3C;
        count  = 4;
        run_frame(8'h00, 0, FL);
        idle_cycle("b2b gap0");
        run_frame(8'hFF, 0, FL);
        idle_cycle("b2b gap1");
        run_frame(8'h3C, 0, FL);
        idle_cycle("b2b tail");
        chkn("b2b pops", head, 4);

        // Enable dropped in the third data bit.
        mem[4] = 8'h5A;
        mem[5] = 8'h81;
        count  = 6;
        run_frame(8'h5A, 14, FL);
        for (int i = 0; i < 6; i++) idle_cycle($sformatf("en low idle %0d", i));
        chkn("en gate pops", head, 5);
        bus.en = 1'b1;
        run_frame(8'h81, 0, FL);

        // Reset pulsed during data bit 5.
        mem[6] = 8'hC3;
        mem[7] = 8'h96;
        count  = 8;
        idle_cycle("pre-abort gap");
        run_frame(8'hC3, 0, 26);
        #1;
        reset = 1'b0;
        #1;
        chk("async rst tx", bus.tx, 1'b1);
        chk("async rst tx_busy", bus.tx_busy, 1'b0);
        chk("async rst fifo_rd", bus.fifo_rd, 1'b0);
        tick();
        chk("rst held tx", bus.tx, 1'b1);
        chk("rst held tx_busy", bus.tx_busy, 1'b0);
        chkn("abort pops", head, 7);
        reset = 1'b1;
        run_frame(8'h96, 0, FL);
        idle_cycle("after abort frame");
        chkn("abort resume pops", head, 8);

`ifdef DEBUG_UART_PARITY_EN
        mem[8] = 8'h07;
        mem[9] = 8'h03;
        count  = 10;
        chk("parity 07 model", exp_bit(8'h07, 9), 1'b1);
        chk("parity 03 model", exp_bit(8'h03, 9), 1'b0);
        run_frame(8'h07, 0, FL);
        idle_cycle("par gap");
        run_frame(8'h03, 0, FL);
        idle_cycle("par tail");
        chkn("parity pops", head, 10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
